// File: rtl/branch_resolver.sv
// branch_resolver: resolves B, B.cond, CBZ and CBNZ against the NZCV flags
// held in sreg[31:28]. Requests arrive over valid/ready from decode and the
// taken/target result leaves over valid/ready towards PC-select. B.cond is
// held back while a flag-setting instruction is still in flight.
//
// Optional feature: define BRANCH_STATS_EN to build saturating counters of
// resolved and taken branches. Without it the stat outputs are tied to zero.
module branch_resolver #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      sreg,
  input  logic             flags_pending,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [3:0]       req_cond,
  input  logic [XLEN-1:0]  req_rt_val,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_offset,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [XLEN-1:0]  resp_target,
  output logic [CNT_W-1:0] stat_resolved,
  output logic [CNT_W-1:0] stat_taken
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_WAIT_FLAGS = 2'b01,
    S_RESP       = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    K_BCOND = 2'b00,
    K_CBZ   = 2'b01,
    K_CBNZ  = 2'b10,
    K_B     = 2'b11
  } kind_t;

  // LEGv8 condition-code evaluation; nzcv is {N,Z,C,V}.
  function automatic logic f_cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c & !z;
      4'b1001: pass = !(c & !z);
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z & (n == v);
      4'b1101: pass = !(!z & (n == v));
      default: pass = 1'b1;  // AL and NV
    endcase
    return pass;
  endfunction

  // Taken target uses the word offset; the shift drops the offset's two MSBs.
  function automatic logic [XLEN-1:0] f_target(input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] offset,
                                               input logic            taken);
    logic [XLEN-1:0] byte_off;
    byte_off = {offset[XLEN-3:0], 2'b00};
    return taken ? (pc + byte_off) : (pc + XLEN'(4));
  endfunction

  state_t          r_state;
  state_t          w_next_state;

  // Request held while B.cond waits for flags to settle.
  logic [3:0]      r_cond;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_offset;

  // Registered response.
  logic            r_taken;
  logic [XLEN-1:0] r_target;

  logic [3:0]      w_nzcv;
  kind_t           w_req_kind;
  logic            w_accept;
  logic            w_req_taken;
  logic [XLEN-1:0] w_req_target;
  logic            w_lat_taken;
  logic [XLEN-1:0] w_lat_target;
  logic            w_latch;
  logic            w_load_resp;
  logic            w_load_taken;
  logic [XLEN-1:0] w_load_target;
  logic            w_resp_hs;
  logic [27:0]     w_unused_sreg;

  assign w_nzcv        = sreg[31:28];
  assign w_unused_sreg = sreg[27:0];
  assign w_req_kind    = kind_t'(req_kind);

  assign req_ready   = (r_state == S_IDLE) | ((r_state == S_RESP) & resp_ready);
  assign w_accept    = req_valid & req_ready;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_taken  = r_taken;
  assign resp_target = r_target;
  assign w_resp_hs   = resp_valid & resp_ready;

  // Resolve the incoming request in its accept cycle.
  always_comb begin
    w_req_taken = 1'b0;
    case (w_req_kind)
      K_BCOND: w_req_taken = f_cond_pass(req_cond, w_nzcv);
      K_CBZ:   w_req_taken = (req_rt_val == '0);
      K_CBNZ:  w_req_taken = (req_rt_val != '0);
      K_B:     w_req_taken = 1'b1;
      default: w_req_taken = 1'b0;
    endcase
    w_req_target = f_target(req_pc, req_offset, w_req_taken);
  end

  // Resolve the stalled B.cond against the current cycle's flags.
  always_comb begin
    w_lat_taken  = f_cond_pass(r_cond, w_nzcv);
    w_lat_target = f_target(r_pc, r_offset, w_lat_taken);
  end

  // Next-state and load-enable decode.
  always_comb begin
    w_next_state  = r_state;
    w_latch       = 1'b0;
    w_load_resp   = 1'b0;
    w_load_taken  = 1'b0;
    w_load_target = '0;
    case (r_state)
      S_IDLE, S_RESP: begin
        // A completed handshake frees the slot; a same-cycle accept refills it.
        if ((r_state == S_RESP) && resp_ready) begin
          w_next_state = S_IDLE;
        end
        if (w_accept) begin
          if ((w_req_kind == K_BCOND) && flags_pending) begin
            w_latch      = 1'b1;
            w_next_state = S_WAIT_FLAGS;
          end else begin
            w_load_resp   = 1'b1;
            w_load_taken  = w_req_taken;
            w_load_target = w_req_target;
            w_next_state  = S_RESP;
          end
        end
      end
      S_WAIT_FLAGS: begin
        if (!flags_pending) begin
          w_load_resp   = 1'b1;
          w_load_taken  = w_lat_taken;
          w_load_target = w_lat_target;
          w_next_state  = S_RESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture a B.cond that must wait for flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cond   <= '0;
      r_pc     <= '0;
      r_offset <= '0;
    end else if (w_latch) begin
      r_cond   <= req_cond;
      r_pc     <= req_pc;
      r_offset <= req_offset;
    end
  end

  // Response register; held until the next load so it is stable under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_taken  <= 1'b0;
      r_target <= '0;
    end else if (w_load_resp) begin
      r_taken  <= w_load_taken;
      r_target <= w_load_target;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_stat_resolved;
  logic [CNT_W-1:0] r_stat_taken;

  // Saturating counts of completed response handshakes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_resolved <= '0;
      r_stat_taken    <= '0;
    end else if (w_resp_hs) begin
      if (r_stat_resolved != '1) begin
        r_stat_resolved <= r_stat_resolved + CNT_W'(1);
      end
      if (r_taken && (r_stat_taken != '1)) begin
        r_stat_taken <= r_stat_taken + CNT_W'(1);
      end
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_taken    = r_stat_taken;
`else
  logic w_unused_hs;
  assign w_unused_hs   = w_resp_hs;
  assign stat_resolved = '0;
  assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             reset;
  logic [31:0]      sreg;
  logic             flags_pending;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_kind;
  logic [3:0]       req_cond;
  logic [XLEN-1:0]  req_rt_val;
  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  req_offset;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_taken;
  logic [XLEN-1:0]  resp_target;
  logic [CNT_W-1:0] stat_resolved;
  logic [CNT_W-1:0] stat_taken;

  int n_cmp;
  int n_err;

  branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .sreg          (sreg),
    .flags_pending (flags_pending),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_cond      (req_cond),
    .req_rt_val    (req_rt_val),
    .req_pc        (req_pc),
    .req_offset    (req_offset),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_taken    (resp_taken),
    .resp_target   (resp_target),
    .stat_resolved (stat_resolved),
    .stat_taken    (stat_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Condition table: {N,Z,C,V}, cond, expected taken.
  logic [3:0] t_nzcv [10] = '{4'h2, 4'h6, 4'h8, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h2};
  logic [3:0] t_cond [10] = '{4'h8, 4'h8, 4'hB, 4'hC, 4'hD, 4'h6, 4'h4, 4'hF, 4'h7, 4'h3};
  logic       t_exp  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Compare-branch / unconditional table, issued with flags_pending=1.
  logic [1:0]      c_kind [6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11};
  logic [XLEN-1:0] c_rt   [6] = '{64'd0, 64'd5, 64'd0, 64'h8000_0000_0000_0000, 64'd7, 64'd0};
  logic [XLEN-1:0] c_pc   [6] = '{64'h300, 64'h400, 64'h400, 64'h500, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0};
  logic [XLEN-1:0] c_off  [6] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 64'd9, 64'hC000_0000_0000_0001, 64'd4};
  logic            c_tk   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [XLEN-1:0] c_tgt  [6] = '{64'h308, 64'h3FC, 64'h404, 64'h504, 64'h14, 64'h0};

  // Present one request for one clock edge; caller is at a negedge.
  task automatic issue(input logic [1:0] kind, input logic [3:0] cond,
                       input logic [XLEN-1:0] rt, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] off);
    req_kind   = kind;
    req_cond   = cond;
    req_rt_val = rt;
    req_pc     = pc;
    req_offset = off;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Consume the current response with a one-cycle resp_ready pulse.
  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", resp_valid); end
    n_cmp++; if (resp_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got=%0b exp=0", resp_taken); end
    n_cmp++; if (resp_target !== 64'h0) begin n_err++; $display("FAIL reset_target got=%h exp=0", resp_target); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
    n_cmp++; if (stat_resolved !== 32'h0) begin n_err++; $display("FAIL reset_stat_resolved got=%0d exp=0", stat_resolved); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got=%0b exp=0", resp_valid); end
  endtask

  task automatic test_bcond_basic();
    sreg = 32'h4000_0000;
    flags_pending = 1'b0;
    issue(2'b00, 4'h0, 64'd0, 64'h100, 64'd4);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL eq_valid got=%0b exp=1", resp_valid); end
    n_cmp++; if (resp_taken !== 1'b1) begin n_err++; $display("FAIL eq_taken got=%0b exp=1", resp_taken); end
    n_cmp++; if (resp_target !== 64'h110) begin n_err++; $display("FAIL eq_target got=%h exp=110", resp_target); end
    consume();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL eq_drop got=%0b exp=0", resp_valid); end
    issue(2'b00, 4'h1, 64'd0, 64'h100, 64'd4);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL ne_valid got=%0b exp=1", resp_valid); end
    n_cmp++; if (resp_taken !== 1'b0) begin n_err++; $display("FAIL ne_taken got=%0b exp=0", resp_taken); end
    n_cmp++; if (resp_target !== 64'h104) begin n_err++; $display("FAIL ne_target got=%h exp=104", resp_target); end
    consume();
  endtask

  task automatic test_cond_table();
    flags_pending = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sreg = {t_nzcv[i], 28'hABC_DEF1};
      issue(2'b00, t_cond[i], 64'd0, 64'h1000, 64'd2);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_taken !== t_exp[i] ||
          resp_target !== (t_exp[i] ? 64'h1008 : 64'h1004)) begin
        n_err++;
        $display("FAIL cond[%0d] cond=%h nzcv=%h got v=%0b t=%0b tgt=%h exp t=%0b",
                 i, t_cond[i], t_nzcv[i], resp_valid, resp_taken, resp_target, t_exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_wait_flags();
    sreg = 32'h9000_0000;
    flags_pending = 1'b1;
    issue(2'b00, 4'hA, 64'd0, 64'h200, 64'd8);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL wait_ready got=%0b exp=0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid got=%0b exp=0", resp_valid); end
    // Flags seen while still pending must not decide the outcome.
    sreg = 32'h8000_0000;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL wait_hold got v=%0b r=%0b exp v=0 r=0", resp_valid, req_ready); end
    flags_pending = 1'b0;
    sreg = 32'h9000_0000;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL wait_resp_valid got=%0b exp=1", resp_valid); end
    n_cmp++; if (resp_taken !== 1'b1) begin n_err++; $display("FAIL wait_taken got=%0b exp=1", resp_taken); end
    n_cmp++; if (resp_target !== 64'h220) begin n_err++; $display("FAIL wait_target got=%h exp=220", resp_target); end
    consume();
  endtask

  task automatic test_cb_no_stall();
    sreg = 32'h0;
    flags_pending = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(c_kind[i], 4'h0, c_rt[i], c_pc[i], c_off[i]);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_taken !== c_tk[i] || resp_target !== c_tgt[i]) begin
        n_err++;
        $display("FAIL cb[%0d] got v=%0b t=%0b tgt=%h exp v=1 t=%0b tgt=%h",
                 i, resp_valid, resp_taken, resp_target, c_tk[i], c_tgt[i]);
      end
      consume();
    end
    flags_pending = 1'b0;
  endtask

  task automatic test_back_to_back();
    flags_pending = 1'b0;
    issue(2'b11, 4'h0, 64'd0, 64'h600, 64'd1);
    req_kind   = 2'b10;
    req_rt_val = 64'd0;
    req_pc     = 64'h700;
    req_offset = 64'd3;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_taken !== 1'b1 || resp_target !== 64'h604 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall[%0d] got v=%0b t=%0b tgt=%h r=%0b exp v=1 t=1 tgt=604 r=0",
                 i, resp_valid, resp_taken, resp_target, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_taken !== 1'b0 || resp_target !== 64'h704) begin
      n_err++;
      $display("FAIL b2b got v=%0b t=%0b tgt=%h exp v=1 t=0 tgt=704", resp_valid, resp_taken, resp_target);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    sreg = 32'h0;
    flags_pending = 1'b1;
    issue(2'b00, 4'h0, 64'd0, 64'h800, 64'd1);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_wait_ready got=%0b exp=0", req_ready); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid got=%0b exp=0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_idle got=%0b exp=1", req_ready); end
    @(negedge clk);
    reset = 1'b1;
    flags_pending = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_resp got=%0b exp=0", resp_valid); end
    resp_ready = 1'b0;
  endtask

  task automatic test_stats();
    flags_pending = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, 4'h0, 64'd0, 64'h900, 64'd1);
      consume();
    end
    for (int i = 0; i < 2; i++) begin
      issue(2'b10, 4'h0, 64'd0, 64'h900, 64'd1);
      consume();
    end
`ifdef BRANCH_STATS_EN
    n_cmp++; if (stat_resolved !== 32'd5) begin n_err++; $display("FAIL stat_resolved got=%0d exp=5", stat_resolved); end
    n_cmp++; if (stat_taken !== 32'd3) begin n_err++; $display("FAIL stat_taken got=%0d exp=3", stat_taken); end
`else
    n_cmp++; if (stat_resolved !== 32'd0) begin n_err++; $display("FAIL stat_resolved got=%0d exp=0", stat_resolved); end
    n_cmp++; if (stat_taken !== 32'd0) begin n_err++; $display("FAIL stat_taken got=%0d exp=0", stat_taken); end
`endif
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b0;
    sreg          = 32'h0;
    flags_pending = 1'b0;
    req_valid     = 1'b0;
    req_kind      = 2'b00;
    req_cond      = 4'h0;
    req_rt_val    = '0;
    req_pc        = '0;
    req_offset    = '0;
    resp_ready    = 1'b0;
    test_reset();
    test_bcond_basic();
    test_cond_table();
    test_wait_flags();
    test_cb_no_stall();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
